// File: rtl/lsu.sv
// Per-thread load/store unit: turns an accepted LDR/STR into one data-memory request and returns load data.
// Latency: issue edge -> REQUESTING -> WAITING (valid high) -> DONE on the ready edge; 3 edges minimum.
// Backpressure: valid, address and data hold in WAITING until the matching ready; DONE holds until retire.
module lsu #(
  parameter int ADDR_BITS = 8,
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 issue,
  input  logic                 retire,
  input  logic                 is_load,
  input  logic                 is_store,
  input  logic [DATA_BITS-1:0] rs_data,
  input  logic [DATA_BITS-1:0] rt_data,
  output logic                 mem_read_valid,
  output logic [ADDR_BITS-1:0] mem_read_address,
  input  logic                 mem_read_ready,
  input  logic [DATA_BITS-1:0] mem_read_data,
  output logic                 mem_write_valid,
  output logic [ADDR_BITS-1:0] mem_write_address,
  output logic [DATA_BITS-1:0] mem_write_data,
  input  logic                 mem_write_ready,
  output logic [1:0]           lsu_state,
  output logic [DATA_BITS-1:0] lsu_out,
  output logic                 wb_valid,
  output logic                 busy
);

  typedef enum logic [1:0] {
    ST_IDLE       = 2'b00,
    ST_REQUESTING = 2'b01,
    ST_WAITING    = 2'b10,
    ST_DONE       = 2'b11
  } state_t;

  state_t                state_q, state_d;
  logic                  op_load_q, op_load_d;
  logic [ADDR_BITS-1:0]  addr_q, addr_d;
  logic [DATA_BITS-1:0]  wdata_q, wdata_d;
  logic [DATA_BITS-1:0]  lsu_out_q, lsu_out_d;
  logic                  wb_valid_q, wb_valid_d;

  logic accept;
  logic req_done;

  // Issue is taken only from IDLE on an active thread with an unambiguous opcode.
  assign accept   = (state_q == ST_IDLE) && enable && issue && (is_load ^ is_store);
  // Only the ready matching the latched operation completes the handshake.
  assign req_done = op_load_q ? mem_read_ready : mem_write_ready;

  // Next-state and datapath latch decisions.
  always_comb begin
    state_d    = state_q;
    op_load_d  = op_load_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    lsu_out_d  = lsu_out_q;
    wb_valid_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          op_load_d = is_load;
          addr_d    = rs_data[ADDR_BITS-1:0];
          if (is_store) wdata_d = rt_data;
          state_d   = ST_REQUESTING;
        end
      end
      ST_REQUESTING: begin
        state_d = ST_WAITING;
      end
      ST_WAITING: begin
        if (req_done) begin
          state_d = ST_DONE;
          if (op_load_q) begin
            lsu_out_d  = mem_read_data;
            wb_valid_d = 1'b1;
          end
        end
      end
      ST_DONE: begin
        // A coincident issue is dropped; the scheduler must reissue from IDLE.
        if (retire) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset clears every visible output immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      op_load_q  <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      lsu_out_q  <= '0;
      wb_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_load_q  <= op_load_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      lsu_out_q  <= lsu_out_d;
      wb_valid_q <= wb_valid_d;
    end
  end

  // Valids are decoded from state so they fall in the same cycle as an async reset.
  assign mem_read_valid    = (state_q == ST_WAITING) &&  op_load_q;
  assign mem_write_valid   = (state_q == ST_WAITING) && !op_load_q;
  assign mem_read_address  = addr_q;
  assign mem_write_address = addr_q;
  assign mem_write_data    = wdata_q;
  assign lsu_state         = state_q;
  assign lsu_out           = lsu_out_q;
  assign wb_valid          = wb_valid_q;
  assign busy              = (state_q != ST_IDLE);

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: load, store, ignored issues, reset mid-transaction, retire/issue collision.
// Inputs change and outputs are sampled 1 ns after the rising edge.
// Every comparison goes through chk, which feeds the summary counters.
module tb_lsu;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable, issue, retire, is_load, is_store;
  logic [7:0] rs_data, rt_data;
  logic       mem_read_valid, mem_read_ready;
  logic [7:0] mem_read_address, mem_read_data;
  logic       mem_write_valid, mem_write_ready;
  logic [7:0] mem_write_address, mem_write_data;
  logic [1:0] lsu_state;
  logic [7:0] lsu_out;
  logic       wb_valid, busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  lsu #(.ADDR_BITS(8), .DATA_BITS(8)) dut (
    .clk               (clk),
    .reset             (reset),
    .enable            (enable),
    .issue             (issue),
    .retire            (retire),
    .is_load           (is_load),
    .is_store          (is_store),
    .rs_data           (rs_data),
    .rt_data           (rt_data),
    .mem_read_valid    (mem_read_valid),
    .mem_read_address  (mem_read_address),
    .mem_read_ready    (mem_read_ready),
    .mem_read_data     (mem_read_data),
    .mem_write_valid   (mem_write_valid),
    .mem_write_address (mem_write_address),
    .mem_write_data    (mem_write_data),
    .mem_write_ready   (mem_write_ready),
    .lsu_state         (lsu_state),
    .lsu_out           (lsu_out),
    .wb_valid          (wb_valid),
    .busy              (busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; enable = 1'b0; issue = 1'b0; retire = 1'b0;
    is_load = 1'b0; is_store = 1'b0; rs_data = '0; rt_data = '0;
    mem_read_ready = 1'b0; mem_read_data = '0; mem_write_ready = 1'b0;
    #12;
    chk("rst_state", lsu_state, 2'b00);
    chk("rst_rvld", mem_read_valid, 0);
    chk("rst_wvld", mem_write_valid, 0);
    chk("rst_raddr", mem_read_address, 0);
    chk("rst_waddr", mem_write_address, 0);
    chk("rst_wdata", mem_write_data, 0);
    chk("rst_out", lsu_out, 0);
    chk("rst_wb", wb_valid, 0);
    chk("rst_busy", busy, 0);
    reset = 1'b1;
    enable = 1'b1;
    step();

    // ---- Load of 0x2A returning 0x5C after 3 waiting cycles ----
    issue = 1'b1; is_load = 1'b1; rs_data = 8'h2A;
    step();
    issue = 1'b0;
    chk("ld_req_state", lsu_state, 2'b01);
    chk("ld_req_rvld", mem_read_valid, 0);
    chk("ld_req_busy", busy, 1);
    step();
    chk("ld_wait_state", lsu_state, 2'b10);
    chk("ld_wait_rvld", mem_read_valid, 1);
    chk("ld_wait_raddr", mem_read_address, 8'h2A);
    // second issue with another address, plus a stray write ready: both ignored
    issue = 1'b1; rs_data = 8'h77; mem_write_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      issue = 1'b0; mem_write_ready = 1'b0;
      chk("ld_hold_state", lsu_state, 2'b10);
      chk("ld_hold_rvld", mem_read_valid, 1);
      chk("ld_hold_raddr", mem_read_address, 8'h2A);
      chk("ld_hold_wvld", mem_write_valid, 0);
    end
    mem_read_ready = 1'b1; mem_read_data = 8'h5C;
    step();
    mem_read_ready = 1'b0; mem_read_data = 8'h00;
    chk("ld_done_state", lsu_state, 2'b11);
    chk("ld_done_rvld", mem_read_valid, 0);
    chk("ld_done_out", lsu_out, 8'h5C);
    chk("ld_done_wb", wb_valid, 1);
    step();
    chk("ld_done2_wb", wb_valid, 0);
    chk("ld_done2_state", lsu_state, 2'b11);
    step();
    chk("ld_done3_state", lsu_state, 2'b11);
    retire = 1'b1;
    step();
    retire = 1'b0;
    chk("ld_ret_state", lsu_state, 2'b00);
    chk("ld_ret_busy", busy, 0);
    step();
    chk("ld_single_state", lsu_state, 2'b00);
    chk("ld_single_rvld", mem_read_valid, 0);
    is_load = 1'b0;

    // ---- Store 0xF0 to 0x10 with write ready already high ----
    issue = 1'b1; is_store = 1'b1; rs_data = 8'h10; rt_data = 8'hF0;
    mem_write_ready = 1'b1;
    step();
    issue = 1'b0;
    chk("st_req_state", lsu_state, 2'b01);
    chk("st_req_wvld", mem_write_valid, 0);
    step();
    chk("st_wait_wvld", mem_write_valid, 1);
    chk("st_wait_waddr", mem_write_address, 8'h10);
    chk("st_wait_wdata", mem_write_data, 8'hF0);
    chk("st_wait_rvld", mem_read_valid, 0);
    step();
    mem_write_ready = 1'b0;
    chk("st_done_state", lsu_state, 2'b11);
    chk("st_done_wvld", mem_write_valid, 0);
    chk("st_done_wb", wb_valid, 0);
    chk("st_done_out", lsu_out, 8'h5C);
    retire = 1'b1;
    step();
    retire = 1'b0; is_store = 1'b0;
    chk("st_ret_state", lsu_state, 2'b00);

    // ---- Ignored issues: both opcodes, then enable low ----
    issue = 1'b1; is_load = 1'b1; is_store = 1'b1; rs_data = 8'h21;
    step();
    chk("both_state", lsu_state, 2'b00);
    chk("both_rvld", mem_read_valid, 0);
    is_store = 1'b0; enable = 1'b0;
    step();
    chk("dis_state", lsu_state, 2'b00);
    chk("dis_busy", busy, 0);
    step();
    issue = 1'b0; enable = 1'b1;
    chk("dis_rvld", mem_read_valid, 0);
    chk("dis_wvld", mem_write_valid, 0);

    // ---- Reset asserted during WAITING ----
    issue = 1'b1; rs_data = 8'h33;
    step();
    issue = 1'b0;
    step();
    chk("rw_wait_rvld", mem_read_valid, 1);
    reset = 1'b0;
    #1;
    chk("rw_rvld", mem_read_valid, 0);
    chk("rw_state", lsu_state, 2'b00);
    chk("rw_raddr", mem_read_address, 0);
    chk("rw_out", lsu_out, 0);
    chk("rw_busy", busy, 0);
    #2;
    reset = 1'b1;
    step();
    mem_read_ready = 1'b1; mem_read_data = 8'h99;
    step();
    mem_read_ready = 1'b0;
    chk("rw_late_state", lsu_state, 2'b00);
    chk("rw_late_out", lsu_out, 0);
    chk("rw_late_wb", wb_valid, 0);

    // ---- Retire and issue together in DONE; minimum 3-edge latency ----
    issue = 1'b1; rs_data = 8'h44; mem_read_ready = 1'b1; mem_read_data = 8'hAB;
    step();
    issue = 1'b0;
    step();
    step();
    mem_read_ready = 1'b0;
    chk("ri_done_state", lsu_state, 2'b11);
    chk("ri_done_out", lsu_out, 8'hAB);
    retire = 1'b1; issue = 1'b1; rs_data = 8'h55;
    step();
    retire = 1'b0;
    chk("ri_idle_state", lsu_state, 2'b00);
    chk("ri_idle_rvld", mem_read_valid, 0);
    step();
    issue = 1'b0;
    chk("ri_fresh_state", lsu_state, 2'b01);
    step();
    chk("ri_fresh_raddr", mem_read_address, 8'h55);
    chk("ri_fresh_rvld", mem_read_valid, 1);
    mem_read_ready = 1'b1; mem_read_data = 8'h66;
    step();
    mem_read_ready = 1'b0;
    chk("ri_fresh_out", lsu_out, 8'h66);
    chk("ri_fresh_wb", wb_valid, 1);
    retire = 1'b1;
    step();
    retire = 1'b0;
    chk("ri_end_state", lsu_state, 2'b00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
